// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I main sequencer.
// Optional feature macro: MC_CTRL_JAL_EN (adds the JAL state and opcode).
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9
`ifdef MC_CTRL_JAL_EN
    ,
    S_JAL      = 4'd10
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MC_CTRL_JAL_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode the sequencer knows how to step through.
  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: return 1'b1;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_outdec.sv
// Combinational state -> control-word decode for the multicycle sequencer.
// Optional feature macro: MC_CTRL_JAL_EN (adds the JAL control word).
module multicycle_ctrl_fsm_outdec
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl
);

  // Control word per state; only memory completion, branch outcome and
  // the illegal-opcode check qualify the otherwise fixed decode.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURES;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        // ALU precomputes the branch/jump target from OldPC + imm.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        if (!op_supported(op)) begin
          ctrl.illegal_op = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        // PC takes the target latched in DECODE while the ALU forms OldPC+4.
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencer for the multicycle RV32I core: FSM register, next-state
// logic and retired-instruction counter; control word from the outdec block.
// Optional feature macro: MC_CTRL_JAL_EN (jal support; otherwise jal is illegal).
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC when memory completes
// DECODE   | dispatch on opcode, ALU forms branch target; flags illegal ops
// MEMADR   | ALU forms rs1+imm load/store address
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | write load data to rd
// MEMWRITE | store access, retire when mem_ready
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1/rs2, take branch on zero
// JAL      | load PC with target, ALU forms return address (macro only)
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state: memory states hold until mem_ready, others advance every cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXEC_R;
          OP_ITYPE:          state_nxt = S_EXEC_I;
          OP_BRANCH:         state_nxt = S_BEQ;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:            state_nxt = S_JAL;
`endif
          default:           state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
      S_EXEC_R:   state_nxt = S_ALUWB;
      S_EXEC_I:   state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
`ifdef MC_CTRL_JAL_EN
      S_JAL:      state_nxt = S_ALUWB;
`endif
      default:    state_nxt = S_FETCH;
    endcase
  end

  multicycle_ctrl_fsm_outdec u_outdec (
    .state     (state),
    .op        (op),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  // Retired-instruction counter; illegal ops finish but do not retire.
  always_ff @(posedge clk) begin
    if (rst)                                    instret <= '0;
    else if (ctrl.instr_done && !ctrl.illegal_op) instret <= instret + CNT_W'(1);
  end

  assign mem_req    = ctrl.mem_req;
  assign pc_write   = ctrl.pc_write;
  assign adr_src    = ctrl.adr_src;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_write  = ctrl.reg_write;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm: per-instruction phase-list model,
// directed latency cases, reset mid-access, then randomized instruction mix.
// Honours MC_CTRL_JAL_EN when compiled with it.
module tb_multicycle_ctrl_fsm;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [6:0] op;
  logic mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .instr_done(instr_done), .illegal_op(illegal_op), .instret(instret)
  );

  localparam logic [15:0] W_REQ  = 16'h8000;
  localparam logic [15:0] W_PCW  = 16'h4000;
  localparam logic [15:0] W_ADR  = 16'h2000;
  localparam logic [15:0] W_MWR  = 16'h1000;
  localparam logic [15:0] W_IRW  = 16'h0800;
  localparam logic [15:0] W_RW   = 16'h0004;
  localparam logic [15:0] W_DONE = 16'h0002;
  localparam logic [15:0] W_ILL  = 16'h0001;

  typedef struct {
    logic [15:0] base;
    logic [15:0] on_ready;
    bit          waits;
    bit          pcw_zero;
    bit          is_fetch;
    bit          is_mem;
  } phase_t;

  phase_t      q[$];
  logic [31:0] model_instret;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  bit          rw_in_rst = 1'b0;

  function automatic logic [15:0] sel(logic [1:0] res, logic [1:0] a, logic [1:0] b, logic [1:0] aop);
    return {5'b0, res, a, b, aop, 3'b0};
  endfunction

  function automatic logic [15:0] act_word();
    return {mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
            alu_src_a, alu_src_b, alu_op, reg_write, instr_done, illegal_op};
  endfunction

  function automatic void push_ph(logic [15:0] base, logic [15:0] on_ready,
                                  bit waits, bit pcw_zero, bit is_fetch, bit is_mem);
    phase_t p;
    p.base = base; p.on_ready = on_ready; p.waits = waits;
    p.pcw_zero = pcw_zero; p.is_fetch = is_fetch; p.is_mem = is_mem;
    q.push_back(p);
  endfunction

  // Expected cycle-by-cycle control words for one whole instruction.
  function automatic void load(logic [6:0] o);
    logic [15:0] dec_w, madr_w, aluwb_w;
    dec_w   = sel(2'b00, 2'b01, 2'b01, 2'b00);
    madr_w  = sel(2'b00, 2'b10, 2'b01, 2'b00);
    aluwb_w = W_RW | W_DONE;
    push_ph(W_REQ | sel(2'b10, 2'b00, 2'b10, 2'b00), W_IRW | W_PCW, 1, 0, 1, 0);
    case (o)
      7'b0000011: begin
        push_ph(dec_w, 0, 0, 0, 0, 0);
        push_ph(madr_w, 0, 0, 0, 0, 0);
        push_ph(W_REQ | W_ADR, 0, 1, 0, 0, 1);
        push_ph(W_RW | W_DONE | sel(2'b01, 2'b00, 2'b00, 2'b00), 0, 0, 0, 0, 0);
      end
      7'b0100011: begin
        push_ph(dec_w, 0, 0, 0, 0, 0);
        push_ph(madr_w, 0, 0, 0, 0, 0);
        push_ph(W_REQ | W_ADR | W_MWR, W_DONE, 1, 0, 0, 1);
      end
      7'b0110011: begin
        push_ph(dec_w, 0, 0, 0, 0, 0);
        push_ph(sel(2'b00, 2'b10, 2'b00, 2'b10), 0, 0, 0, 0, 0);
        push_ph(aluwb_w, 0, 0, 0, 0, 0);
      end
      7'b0010011: begin
        push_ph(dec_w, 0, 0, 0, 0, 0);
        push_ph(sel(2'b00, 2'b10, 2'b01, 2'b10), 0, 0, 0, 0, 0);
        push_ph(aluwb_w, 0, 0, 0, 0, 0);
      end
      7'b1100011: begin
        push_ph(dec_w, 0, 0, 0, 0, 0);
        push_ph(W_DONE | sel(2'b00, 2'b10, 2'b00, 2'b01), 0, 0, 1, 0, 0);
      end
`ifdef MC_CTRL_JAL_EN
      7'b1101111: begin
        push_ph(dec_w, 0, 0, 0, 0, 0);
        push_ph(W_PCW | sel(2'b00, 2'b01, 2'b10, 2'b00), 0, 0, 0, 0, 0);
        push_ph(aluwb_w, 0, 0, 0, 0, 0);
      end
`endif
      default: push_ph(dec_w | W_ILL | W_DONE, 0, 0, 0, 0, 0);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model head every cycle.
  always @(negedge clk) begin
    phase_t      ph;
    logic [15:0] exp;
    if (rst && reg_write) rw_in_rst = 1'b1;
    if (chk_en && q.size() != 0) begin
      ph  = q[0];
      exp = ph.base;
      if (!ph.waits || mem_ready) exp = exp | ph.on_ready;
      if (ph.pcw_zero && zero)    exp = exp | W_PCW;
      check("ctrl_word", {16'h0, act_word()}, {16'h0, exp});
      check("instret", instret, model_instret);
      if (!ph.waits || mem_ready) begin
        void'(q.pop_front());
        if (exp[1] && !exp[0]) model_instret = model_instret + 1;
      end
    end
  end

  // Runs one instruction; fw/mw are wait cycles in FETCH and in the data access.
  task automatic run_instr(input logic [6:0] o, input int fw, input int mw,
                           input logic zv, output int cycles);
    cycles = 0;
    op = o; zero = zv;
    load(o);
    do begin
      if (q[0].is_fetch && fw > 0) begin mem_ready = 1'b0; fw--; end
      else if (q[0].is_mem && mw > 0) begin mem_ready = 1'b0; mw--; end
      else if (q[0].waits) mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      cycles++;
      @(posedge clk); #1;
    end while (q.size() != 0 && cycles < 100);
    check("instr_finished", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [6:0]  o;
    rst = 1'b1; op = 7'b0; zero = 1'b0; mem_ready = 1'b0; model_instret = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd1);
    check("rst_adr_src", 32'(adr_src), 32'd0);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_instret", instret, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_instr(7'b0110011, 0, 0, 1'b0, cyc);
    check("add_cycles", 32'(cyc), 32'd4);
    check("add_instret", instret, 32'd1);
    run_instr(7'b0000011, 3, 2, 1'b0, cyc);
    check("lw_wait_cycles", 32'(cyc), 32'd10);
    check("lw_instret", instret, 32'd2);
    run_instr(7'b0100011, 0, 0, 1'b0, cyc);
    check("sw_cycles", 32'(cyc), 32'd4);
    run_instr(7'b1100011, 0, 0, 1'b1, cyc);
    check("beq_taken_cycles", 32'(cyc), 32'd3);
    run_instr(7'b1100011, 0, 0, 1'b0, cyc);
    check("beq_not_taken_cycles", 32'(cyc), 32'd3);
    check("beq_instret", instret, 32'd5);
    run_instr(7'b1111111, 0, 0, 1'b0, cyc);
    check("illegal_cycles", 32'(cyc), 32'd2);
    check("illegal_instret", instret, 32'd5);
    run_instr(7'b0010011, 1, 0, 1'b0, cyc);
    check("addi_cycles", 32'(cyc), 32'd5);
    check("addi_instret", instret, 32'd6);
`ifdef MC_CTRL_JAL_EN
    run_instr(7'b1101111, 0, 0, 1'b0, cyc);
    check("jal_cycles", 32'(cyc), 32'd4);
    check("jal_instret", instret, 32'd7);
`else
    run_instr(7'b1101111, 0, 0, 1'b0, cyc);
    check("jal_illegal_cycles", 32'(cyc), 32'd2);
    check("jal_illegal_instret", instret, 32'd6);
`endif

    // Reset held two cycles while a load waits in MEMREAD.
    op = 7'b0000011; zero = 1'b0;
    load(op);
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    q.delete();
    model_instret = 0;
    #1;
    check("post_rst_instret", instret, 32'd0);
    check("post_rst_mem_req", 32'(mem_req), 32'd1);
    check("post_rst_adr_src", 32'(adr_src), 32'd0);
    check("rst_no_reg_write", 32'(rw_in_rst), 32'd0);
    chk_en = 1'b1;

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b0110011;
        3: o = 7'b0010011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        default: o = 7'($urandom);
      endcase
      run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), cyc);
    end
    check("final_instret", instret, model_instret);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
